// File: rtl/uc_pkg.sv
// Shared encodings for the RV64I multicycle control unit: FSM states, opcodes,
// instruction classes and the pc_src / wb_sel / imm_sel select values.
package uc_pkg;

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    MEMORIA    = 3'd3,
    ESCRITA    = 3'd4,
    ERRO       = 3'd5
  } estado_t;

  typedef enum logic [3:0] {
    CL_NENHUMA,
    CL_R,
    CL_ADDI,
    CL_AUIPC,
    CL_LD,
    CL_SD,
    CL_BEQ,
    CL_JAL,
    CL_JALR
  } classe_t;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_BRANCH = 7'h63;

  localparam logic [1:0] PC_MAIS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] WB_ULA   = 2'd0;
  localparam logic [1:0] WB_MEM   = 2'd1;
  localparam logic [1:0] WB_PC4   = 2'd2;
  localparam logic [1:0] WB_AUIPC = 2'd3;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  function automatic logic eh_memoria(input classe_t c);
    return (c == CL_LD) || (c == CL_SD);
  endfunction

endpackage

// File: rtl/uc_decodificador.sv
// Combinational decode of opcode/funct3/funct7 into an instruction class;
// anything outside ld/sd/add/sub/addi/jal/jalr/auipc/beq is flagged illegal.
module uc_decodificador
  import uc_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output classe_t    classe,
  output logic       legal
);

  always_comb begin
    classe = CL_NENHUMA;
    case (opcode)
      OPC_LOAD:   if (funct3 == 3'b011) classe = CL_LD;
      OPC_STORE:  if (funct3 == 3'b011) classe = CL_SD;
      OPC_OP:     if (funct3 == 3'b000 && (funct7 == 7'h00 || funct7 == 7'h20)) classe = CL_R;
      OPC_OP_IMM: if (funct3 == 3'b000) classe = CL_ADDI;
      OPC_JAL:    classe = CL_JAL;
      OPC_JALR:   if (funct3 == 3'b000) classe = CL_JALR;
      OPC_AUIPC:  classe = CL_AUIPC;
      OPC_BRANCH: if (funct3 == 3'b000) classe = CL_BEQ;
      default:    classe = CL_NENHUMA;
    endcase
  end

  assign legal = (classe != CL_NENHUMA);

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the RV64I datapath (BUSCA/DECODIFICA/EXECUTA/MEMORIA/ESCRITA/ERRO).
// Optional UC_CONTADOR_RETIRADAS_EN adds the instr_retiradas counter output.
module unidade_controle_multiciclo
  import uc_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int LAT_MAX_MEM = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        ula_zero,
  input  logic        mem_pronto,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        WeR,
  output logic [1:0]  wb_sel,
  output logic        WeM,
  output logic        mem_re,
  output logic        soma_ou_subtrai,
  output logic        subtraindo,
  output logic        imediato,
  output logic [2:0]  imm_sel,
  output logic [2:0]  estado_atual,
  output logic        instr_ilegal
`ifdef UC_CONTADOR_RETIRADAS_EN
  ,
  output logic [XLEN-1:0] instr_retiradas
`endif
);

  localparam int CW = $clog2(LAT_MAX_MEM + 1);

  estado_t         estado_reg;
  classe_t         classe_reg;
  logic            sub_reg;
  logic [CW-1:0]   espera_reg;
  classe_t         classe_dec;
  logic            legal_dec;
  logic            unused_bits;

  uc_decodificador u_decodificador (
    .opcode (instr[6:0]),
    .funct3 (instr[14:12]),
    .funct7 (instr[31:25]),
    .classe (classe_dec),
    .legal  (legal_dec)
  );

  // Register/immediate fields are consumed by the datapath, not here.
  assign unused_bits = ^{instr[24:15], instr[11:7], (XLEN > 0)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_reg <= BUSCA;
      classe_reg <= CL_NENHUMA;
      sub_reg    <= 1'b0;
      espera_reg <= '0;
    end else begin
      case (estado_reg)
        BUSCA: estado_reg <= DECODIFICA;
        DECODIFICA: begin
          classe_reg <= classe_dec;
          sub_reg    <= instr[30];
          estado_reg <= legal_dec ? EXECUTA : ERRO;
        end
        EXECUTA: begin
          espera_reg <= '0;
          if (eh_memoria(classe_reg))
            estado_reg <= MEMORIA;
          else if (classe_reg == CL_R || classe_reg == CL_ADDI || classe_reg == CL_AUIPC)
            estado_reg <= ESCRITA;
          else
            estado_reg <= BUSCA;
        end
        MEMORIA: begin
          // mem_pronto takes priority over a timeout landing in the same cycle
          if (mem_pronto)
            estado_reg <= (classe_reg == CL_SD) ? BUSCA : ESCRITA;
          else if (espera_reg == CW'(LAT_MAX_MEM - 1))
            estado_reg <= ERRO;
          else
            espera_reg <= espera_reg + 1'b1;
        end
        ESCRITA: estado_reg <= BUSCA;
        ERRO:    estado_reg <= ERRO;
        default: estado_reg <= BUSCA;
      endcase
    end
  end

  always_comb begin
    ir_we           = rst_n && (estado_reg == BUSCA);
    pc_we           = 1'b0;
    pc_src          = PC_MAIS4;
    WeR             = 1'b0;
    wb_sel          = WB_ULA;
    WeM             = 1'b0;
    mem_re          = 1'b0;
    soma_ou_subtrai = 1'b0;
    subtraindo      = 1'b0;
    imediato        = 1'b0;
    imm_sel         = IMM_I;

    // ULA/immediate controls stay stable for the whole instruction body
    if (estado_reg == EXECUTA || estado_reg == MEMORIA || estado_reg == ESCRITA) begin
      case (classe_reg)
        CL_R: begin
          soma_ou_subtrai = 1'b1;
          subtraindo      = sub_reg;
        end
        CL_ADDI, CL_LD: imediato = 1'b1;
        CL_SD: begin
          imediato = 1'b1;
          imm_sel  = IMM_S;
        end
        CL_AUIPC: imm_sel = IMM_U;
        CL_BEQ: begin
          subtraindo = 1'b1;
          imm_sel    = IMM_B;
        end
        CL_JAL:  imm_sel = IMM_J;
        default: imm_sel = IMM_I;
      endcase
    end

    case (estado_reg)
      EXECUTA: begin
        case (classe_reg)
          CL_BEQ: begin
            pc_we  = 1'b1;
            pc_src = ula_zero ? PC_IMM : PC_MAIS4;
          end
          CL_JAL: begin
            WeR    = 1'b1;
            wb_sel = WB_PC4;
            pc_we  = 1'b1;
            pc_src = PC_IMM;
          end
          CL_JALR: begin
            WeR    = 1'b1;
            wb_sel = WB_PC4;
            pc_we  = 1'b1;
            pc_src = PC_JALR;
          end
          default: pc_we = 1'b0;
        endcase
      end
      MEMORIA: begin
        WeM    = (classe_reg == CL_SD);
        mem_re = (classe_reg == CL_LD);
        pc_we  = (classe_reg == CL_SD) && mem_pronto;
      end
      ESCRITA: begin
        WeR   = 1'b1;
        pc_we = 1'b1;
        if (classe_reg == CL_LD)
          wb_sel = WB_MEM;
        else if (classe_reg == CL_AUIPC)
          wb_sel = WB_AUIPC;
        else
          wb_sel = WB_ULA;
      end
      default: pc_we = 1'b0;
    endcase
  end

  assign estado_atual = estado_reg;
  assign instr_ilegal = (estado_reg == ERRO);

`ifdef UC_CONTADOR_RETIRADAS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instr_retiradas <= '0;
    else if (pc_we && estado_reg != ERRO)
      instr_retiradas <= instr_retiradas + 1'b1;
  end
`endif

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for unidade_controle_multiciclo: directed table, random
// instruction stream against a per-instruction trace model, and timeout/reset corners.
module tb_unidade_controle_multiciclo;

  localparam int M_ADD = 0, M_SUB = 1, M_ADDI = 2, M_AUIPC = 3, M_LD = 4;
  localparam int M_SD = 5, M_BEQ = 6, M_JAL = 7, M_JALR = 8, M_ILEG = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        ula_zero;
  logic        mem_pronto;
  logic        ir_we, pc_we, WeR, WeM, mem_re;
  logic [1:0]  pc_src, wb_sel;
  logic        soma_ou_subtrai, subtraindo, imediato;
  logic [2:0]  imm_sel, estado_atual;
  logic        instr_ilegal;
`ifdef UC_CONTADOR_RETIRADAS_EN
  logic [63:0] instr_retiradas;
  logic [63:0] ret_esp;
`endif

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        pronto;
    logic        zero;
    logic [18:0] esp;
  } passo_t;
  passo_t fila[$];

  typedef struct {
    logic [31:0] w;
    int          esp;
    logic        z;
    int          lat;
    int          nmem;
    logic [18:0] exe;
  } vet_t;
  vet_t tab[12];

  unidade_controle_multiciclo dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr           (instr),
    .ula_zero        (ula_zero),
    .mem_pronto      (mem_pronto),
    .ir_we           (ir_we),
    .pc_we           (pc_we),
    .pc_src          (pc_src),
    .WeR             (WeR),
    .wb_sel          (wb_sel),
    .WeM             (WeM),
    .mem_re          (mem_re),
    .soma_ou_subtrai (soma_ou_subtrai),
    .subtraindo      (subtraindo),
    .imediato        (imediato),
    .imm_sel         (imm_sel),
    .estado_atual    (estado_atual),
    .instr_ilegal    (instr_ilegal)
`ifdef UC_CONTADOR_RETIRADAS_EN
    ,
    .instr_retiradas (instr_retiradas)
`endif
  );

  always #5 clk = ~clk;

  // {estado, ir_we, pc_we, pc_src, WeR, wb_sel, WeM, mem_re, {soma, sub, imediato, imm_sel}, ilegal}
  function automatic logic [18:0] mk(int e, bit irw, bit pcw, int pcs, bit wer, int wbs,
                                     bit wem, bit mre, logic [5:0] a, bit il);
    logic [2:0] e3;
    logic [1:0] p2, w2;
    e3 = e[2:0];
    p2 = pcs[1:0];
    w2 = wbs[1:0];
    return {e3, irw, pcw, p2, wer, w2, wem, mre, a, il};
  endfunction

  function automatic logic [18:0] obs();
    return {estado_atual, ir_we, pc_we, pc_src, WeR, wb_sel, WeM, mem_re,
            soma_ou_subtrai, subtraindo, imediato, imm_sel, instr_ilegal};
  endfunction

  function automatic logic [5:0] alu_de(int mn);
    case (mn)
      M_ADD:   return 6'b100_000;
      M_SUB:   return 6'b110_000;
      M_ADDI:  return 6'b001_000;
      M_AUIPC: return 6'b000_011;
      M_LD:    return 6'b001_000;
      M_SD:    return 6'b001_001;
      M_BEQ:   return 6'b010_010;
      M_JAL:   return 6'b000_100;
      default: return 6'b000_000;
    endcase
  endfunction

  function automatic logic [31:0] gera(int mn);
    logic [31:0] w;
    w = $urandom;
    case (mn)
      M_ADD:   begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h00; end
      M_SUB:   begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h20; end
      M_ADDI:  begin w[6:0] = 7'h13; w[14:12] = 3'd0; end
      M_AUIPC: w[6:0] = 7'h17;
      M_LD:    begin w[6:0] = 7'h03; w[14:12] = 3'd3; end
      M_SD:    begin w[6:0] = 7'h23; w[14:12] = 3'd3; end
      M_BEQ:   begin w[6:0] = 7'h63; w[14:12] = 3'd0; end
      M_JAL:   w[6:0] = 7'h6F;
      default: begin w[6:0] = 7'h67; w[14:12] = 3'd0; end
    endcase
    return w;
  endfunction

  // Expected cycle-by-cycle trace of one instruction, with the inputs to drive each cycle.
  function automatic void modelo(int mn, int espera, int n_erro);
    passo_t     p;
    logic [5:0] a;
    bit         eh_ld, eh_sd, pcw, wer;
    int         pcs, wbs;
    fila.delete();
    a = alu_de(mn);
    eh_ld = (mn == M_LD);
    eh_sd = (mn == M_SD);
    p.pronto = 1'($urandom); p.zero = 1'($urandom);
    p.esp = mk(0, 1, 0, 0, 0, 0, 0, 0, 6'b0, 0);
    fila.push_back(p);
    p.pronto = 1'($urandom); p.zero = 1'($urandom);
    p.esp = mk(1, 0, 0, 0, 0, 0, 0, 0, 6'b0, 0);
    fila.push_back(p);
    if (mn == M_ILEG) begin
      for (int k = 0; k < n_erro; k++) begin
        p.pronto = 1'($urandom); p.zero = 1'($urandom);
        p.esp = mk(5, 0, 0, 0, 0, 0, 0, 0, 6'b0, 1);
        fila.push_back(p);
      end
      return;
    end
    pcw = 0; wer = 0; pcs = 0; wbs = 0;
    p.pronto = 1'($urandom); p.zero = 1'($urandom);
    if (mn == M_BEQ) begin pcw = 1; pcs = p.zero ? 1 : 0; end
    if (mn == M_JAL) begin pcw = 1; pcs = 1; wer = 1; wbs = 2; end
    if (mn == M_JALR) begin pcw = 1; pcs = 2; wer = 1; wbs = 2; end
    p.esp = mk(2, 0, pcw, pcs, wer, wbs, 0, 0, a, 0);
    fila.push_back(p);
    if (eh_ld || eh_sd) begin
      for (int k = 0; k < 16 && k <= espera; k++) begin
        p.pronto = (k == espera);
        p.zero = 1'($urandom);
        p.esp = mk(3, 0, eh_sd && p.pronto, 0, 0, 0, eh_sd, eh_ld, a, 0);
        fila.push_back(p);
      end
      if (espera >= 16) begin
        for (int k = 0; k < n_erro; k++) begin
          p.pronto = 1'($urandom); p.zero = 1'($urandom);
          p.esp = mk(5, 0, 0, 0, 0, 0, 0, 0, 6'b0, 1);
          fila.push_back(p);
        end
        return;
      end
    end
    if (mn == M_ADD || mn == M_SUB || mn == M_ADDI || mn == M_AUIPC || eh_ld) begin
      wbs = eh_ld ? 1 : (mn == M_AUIPC) ? 3 : 0;
      p.pronto = 1'($urandom); p.zero = 1'($urandom);
      p.esp = mk(4, 0, 1, 0, 1, wbs, 0, 0, a, 0);
      fila.push_back(p);
    end
  endfunction

  task automatic compara(input string nome, input logic [18:0] got, input logic [18:0] esp);
    n_chk++;
    if (got !== esp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nome, got, esp);
    end
  endtask

  task automatic compara_int(input string nome, input int got, input int esp);
    n_chk++;
    if (got != esp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nome, got, esp);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic executa(input logic [31:0] w, input string nome, input int n_max);
    instr = w;
    for (int i = 0; i < fila.size() && i < n_max; i++) begin
      mem_pronto = fila[i].pronto;
      ula_zero   = fila[i].zero;
      @(negedge clk);
      compara($sformatf("%s instr=%h passo %0d", nome, w, i), obs(), fila[i].esp);
`ifdef UC_CONTADOR_RETIRADAS_EN
      ret_esp = ret_esp + 64'(fila[i].esp[14]);
`endif
      @(posedge clk);
      #1;
    end
    $display("%s instr=%h passos=%0d", nome, w, (fila.size() < n_max) ? fila.size() : n_max);
  endtask

  task automatic aplica_reset();
    rst_n = 1'b0;
    #1;
    compara("reset saidas", obs(), 19'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
`ifdef UC_CONTADOR_RETIRADAS_EN
    ret_esp = '0;
    n_chk++;
    if (instr_retiradas !== 64'd0) begin
      n_fail++;
      $display("FAIL reset contador: got %0d expected 0", instr_retiradas);
    end
`endif
  endtask

  initial begin
    int mn, esp, lat, nmem;
    bit feito;
    logic [18:0] exe_obs;

    rst_n = 1'b1; instr = 32'h0; ula_zero = 1'b0; mem_pronto = 1'b0;
    tab[0]  = '{32'h002081B3, 0, 1'b0, 4, 0, mk(2,0,0,0,0,0,0,0,6'b100_000,0)};
    tab[1]  = '{32'h402081B3, 0, 1'b0, 4, 0, mk(2,0,0,0,0,0,0,0,6'b110_000,0)};
    tab[2]  = '{32'h0080B283, 2, 1'b0, 7, 3, mk(2,0,0,0,0,0,0,0,6'b001_000,0)};
    tab[3]  = '{32'h00208863, 0, 1'b1, 3, 0, mk(2,0,1,1,0,0,0,0,6'b010_010,0)};
    tab[4]  = '{32'h00208863, 0, 1'b0, 3, 0, mk(2,0,1,0,0,0,0,0,6'b010_010,0)};
    tab[5]  = '{32'h040202E7, 0, 1'b0, 3, 0, mk(2,0,1,2,1,2,0,0,6'b000_000,0)};
    tab[6]  = '{32'h00500093, 0, 1'b0, 4, 0, mk(2,0,0,0,0,0,0,0,6'b001_000,0)};
    tab[7]  = '{32'h00001097, 0, 1'b0, 4, 0, mk(2,0,0,0,0,0,0,0,6'b000_011,0)};
    tab[8]  = '{32'h008000EF, 0, 1'b0, 3, 0, mk(2,0,1,1,1,2,0,0,6'b000_100,0)};
    tab[9]  = '{32'h0020B423, 0, 1'b0, 4, 1, mk(2,0,0,0,0,0,0,0,6'b001_001,0)};
    tab[10] = '{32'h0020B423, 5, 1'b0, 9, 6, mk(2,0,0,0,0,0,0,0,6'b001_001,0)};
    tab[11] = '{32'h0080B283, 0, 1'b1, 5, 1, mk(2,0,0,0,0,0,0,0,6'b001_000,0)};

    @(posedge clk);
    #1;
    aplica_reset();

    // Random instruction stream against the trace model
    for (int t = 0; t < 60; t++) begin
      mn = $urandom_range(0, 8);
      esp = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 4);
      modelo(mn, esp, 0);
      executa(gera(mn), "aleatorio", 1000);
    end
`ifdef UC_CONTADOR_RETIRADAS_EN
    n_chk++;
    if (instr_retiradas !== ret_esp) begin
      n_fail++;
      $display("FAIL contador retiradas: got %0d expected %0d", instr_retiradas, ret_esp);
    end
`endif

    // Directed table: latency, EXECUTA outputs and memory-enable cycles
    foreach (tab[v]) begin
      instr = tab[v].w;
      ula_zero = tab[v].z;
      lat = 0; nmem = 0; feito = 0; exe_obs = '0;
      for (int c = 0; c < 40 && !feito; c++) begin
        mem_pronto = (estado_atual == 3'd3) && (nmem == tab[v].esp);
        @(negedge clk);
        if (estado_atual == 3'd2) exe_obs = obs();
        if (WeM || mem_re) nmem++;
        @(posedge clk);
        #1;
        lat++;
        if (estado_atual == 3'd0) feito = 1;
      end
      compara_int($sformatf("tabela %0d latencia", v), lat, tab[v].lat);
      compara($sformatf("tabela %0d executa", v), exe_obs, tab[v].exe);
      compara_int($sformatf("tabela %0d ciclos memoria", v), nmem, tab[v].nmem);
      $display("tabela %0d instr=%h ciclos=%0d mem=%0d", v, tab[v].w, lat, nmem);
    end

    // Illegal opcode held in ERRO for 20 cycles
    modelo(M_ILEG, 0, 20);
    executa(32'h0000007F, "ilegal opcode", 1000);
    aplica_reset();
    modelo(M_ILEG, 0, 3);
    executa(32'h022081B3, "ilegal funct7", 1000);
    aplica_reset();

    // sd with no mem_pronto for 16 cycles times out
    modelo(M_SD, 16, 5);
    executa(gera(M_SD), "sd timeout", 1000);
    aplica_reset();

    // mem_pronto on the last allowed cycle beats the timeout
    modelo(M_LD, 15, 0);
    executa(gera(M_LD), "ld pronto limite", 1000);
    modelo(M_SD, 15, 0);
    executa(gera(M_SD), "sd pronto limite", 1000);

    // Reset in the middle of MEMORIA, then a clean instruction
    modelo(M_LD, 3, 0);
    executa(gera(M_LD), "ld abortado", 4);
    aplica_reset();
    modelo(M_ADD, 0, 0);
    executa(32'h002081B3, "add apos reset", 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
